// File: rtl/kernel_bc_fifo_pkg.sv
// Shared helpers for multi-reader start-token FIFOs.
//   count_width : width of a per-channel token counter (0..DEPTH) for a given address width
//   max_count   : largest of up to MAX_CH channel counters; entries at index >= num_ch are ignored
package kernel_bc_fifo_pkg;

    localparam int MAX_CH = 8;
    localparam int MAX_CW = 16;

    typedef logic [MAX_CW-1:0] cnt_wide_t;
    typedef cnt_wide_t [MAX_CH-1:0] cnt_vec_t;

    // A counter must hold DEPTH itself, which can be 2**addr_width.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic cnt_wide_t max_count(input cnt_vec_t cnts, input int num_ch);
        cnt_wide_t m;
        m = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < num_ch && cnts[i] > m) begin
                m = cnts[i];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/kernel_bc_start_bcast_fifo_if.sv
// Bus bundle of the broadcast start FIFO.
//   write side : if_din, if_write, if_write_ce -> if_full_n, if_almost_full
//   read side  : if_read[c], if_read_ce[c]     -> if_empty_n[c], if_dout[c], if_count[c]
// master = producer/consumers, slave = the FIFO.
interface kernel_bc_start_bcast_fifo_if
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_CH     = 2
) ();

    localparam int CW = count_width(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0]        if_din;
    logic                         if_write;
    logic                         if_write_ce;
    logic                         if_full_n;
    logic                         if_almost_full;
    logic [NUM_CH-1:0]            if_read;
    logic [NUM_CH-1:0]            if_read_ce;
    logic [NUM_CH-1:0]            if_empty_n;
    logic [NUM_CH*DATA_WIDTH-1:0] if_dout;
    logic [NUM_CH*CW-1:0]         if_count;

    modport master (
        output if_din, if_write, if_write_ce, if_read, if_read_ce,
        input  if_full_n, if_almost_full, if_empty_n, if_dout, if_count
    );

    modport slave (
        input  if_din, if_write, if_write_ce, if_read, if_read_ce,
        output if_full_n, if_almost_full, if_empty_n, if_dout, if_count
    );

endinterface

// File: rtl/kernel_bc_start_bcast_fifo_shiftReg.sv
// DEPTH-entry shift register with NUM_CH combinational read ports.
//   clk    : clock
//   i_ce   : shift enable; entry 0 loads i_data, entry k loads entry k-1
//   i_data : token to insert
//   i_addr : NUM_CH packed read addresses, ADDR_WIDTH bits each
//   o_q    : NUM_CH packed read data, DATA_WIDTH bits each (zero for addr >= DEPTH)
// Storage is intentionally not reset; readers are gated by their counters.
module kernel_bc_start_bcast_fifo_shiftReg
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2
) (
    input  logic                         clk,
    input  logic                         i_ce,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    always_comb begin
        o_q = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            // Guard for non-power-of-two DEPTH where the address space is larger.
            if (int'(i_addr[c*ADDR_WIDTH +: ADDR_WIDTH]) < DEPTH) begin
                o_q[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_addr[c*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

endmodule

// File: rtl/kernel_bc_start_bcast_fifo.sv
// Start-token FIFO with one writer and NUM_CH independent readers. Every token is
// delivered once to each reader; its slot is freed when the slowest reader takes it.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of kernel_bc_start_bcast_fifo_if (write port, per-channel
//                read ports, flags, per-channel head data and unread counts)
// Channel c's unread tokens sit at entries 0..cnt[c]-1 of the shift register, newest
// at 0, so its head is entry cnt[c]-1. Physical occupancy is the largest counter.
module kernel_bc_start_bcast_fifo
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int ADDR_WIDTH   = 2,
    parameter int DEPTH        = 4,
    parameter int NUM_CH       = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    kernel_bc_start_bcast_fifo_if.slave   bus
);

    localparam int CW = count_width(ADDR_WIDTH);

    logic [CW-1:0]                r_cnt [NUM_CH];

    cnt_vec_t                     w_cnt_vec;
    logic [CW-1:0]                w_occ;
    logic                         w_full_n;
    logic                         w_almost_full;
    logic                         w_wr;
    logic [NUM_CH-1:0]            w_rd;
    logic [NUM_CH-1:0]            w_empty_n;
    logic [NUM_CH*ADDR_WIDTH-1:0] w_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] w_q;
    logic [NUM_CH*DATA_WIDTH-1:0] w_dout;
    logic [NUM_CH*CW-1:0]         w_count;

    // Everything here is decoded from r_cnt only, so no input reaches a flag.
    always_comb begin
        w_cnt_vec = '0;
        w_empty_n = '0;
        w_addr    = '0;
        w_dout    = '0;
        w_count   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cnt_vec[c]                     = MAX_CW'(r_cnt[c]);
            w_empty_n[c]                     = (r_cnt[c] != '0);
            // Wraps to all-ones when the channel is empty; the data is masked below.
            w_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(r_cnt[c] - CW'(1));
            w_count[c*CW +: CW]              = r_cnt[c];
            if (r_cnt[c] != '0) begin
                w_dout[c*DATA_WIDTH +: DATA_WIDTH] = w_q[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_occ         = CW'(max_count(w_cnt_vec, NUM_CH));
    assign w_full_n      = (w_occ < CW'(DEPTH));
    assign w_almost_full = (w_occ >= CW'(AFULL_THRESH));

    assign w_wr = bus.if_write & bus.if_write_ce & w_full_n;
    assign w_rd = bus.if_read & bus.if_read_ce & w_empty_n;

    // A write adds a token to every channel; a read removes one from that channel only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ({w_wr, w_rd[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CW'(1);
                    2'b01:   r_cnt[c] <= r_cnt[c] - CW'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    kernel_bc_start_bcast_fifo_shiftReg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_CH     (NUM_CH)
    ) u_shiftReg (
        .clk    (clk),
        .i_ce   (w_wr),
        .i_data (bus.if_din),
        .i_addr (w_addr),
        .o_q    (w_q)
    );

    assign bus.if_full_n      = w_full_n;
    assign bus.if_almost_full = w_almost_full;
    assign bus.if_empty_n     = w_empty_n;
    assign bus.if_dout        = w_dout;
    assign bus.if_count       = w_count;

endmodule

// File: tb/tb_kernel_bc_start_bcast_fifo.sv
// Directed + random bench for the broadcast start FIFO (DEPTH=4, NUM_CH=2, 8-bit tokens).
// A per-channel queue holds the tokens each reader still owes; reads pop and compare.
module tb_kernel_bc_start_bcast_fifo;

    localparam int DW     = 8;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 2;
    localparam int THRESH = 3;
    localparam int CW     = AW + 1;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [NUM_CH][$];

    kernel_bc_start_bcast_fifo_if #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NUM_CH)
    ) bus ();

    kernel_bc_start_bcast_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .NUM_CH       (NUM_CH),
        .AFULL_THRESH (THRESH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_occ();
        int m = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (exp_q[c].size() > m) m = exp_q[c].size();
        end
        return m;
    endfunction

    function automatic logic [31:0] dout_of(input int c);
        return 32'(bus.if_dout[c*DW +: DW]);
    endfunction

    function automatic logic [31:0] count_of(input int c);
        return 32'(bus.if_count[c*CW +: CW]);
    endfunction

    task automatic check_state();
        int occ;
        occ = model_occ();
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("empty_n%0d", c), 32'(bus.if_empty_n[c]), 32'(exp_q[c].size() != 0));
            check($sformatf("count%0d", c), count_of(c), 32'(exp_q[c].size()));
            check($sformatf("head%0d", c), dout_of(c),
                  (exp_q[c].size() != 0) ? 32'(exp_q[c][0]) : 32'd0);
        end
        check("full_n", 32'(bus.if_full_n), 32'(occ < DEPTH));
        check("almost_full", 32'(bus.if_almost_full), 32'(occ >= THRESH));
    endtask

    // Advance one clock with the inputs currently driven, updating the model.
    task automatic tick();
        bit              wr_eff;
        bit [NUM_CH-1:0] rd_eff;
        logic [DW-1:0]   din;
        logic [DW-1:0]   e;
        din    = bus.if_din;
        wr_eff = !reset && bus.if_write && bus.if_write_ce && (model_occ() < DEPTH);
        for (int c = 0; c < NUM_CH; c++) begin
            rd_eff[c] = !reset && bus.if_read[c] && bus.if_read_ce[c] && (exp_q[c].size() != 0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_eff[c]) begin
                e = exp_q[c].pop_front();
                check($sformatf("rd_data%0d", c), dout_of(c), 32'(e));
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        end else if (wr_eff) begin
            for (int c = 0; c < NUM_CH; c++) exp_q[c].push_back(din);
        end
        #1;
        check_state();
    endtask

    task automatic drive(input bit wr, input bit wce, input logic [DW-1:0] din,
                         input bit [NUM_CH-1:0] rd, input bit [NUM_CH-1:0] rce);
        bus.if_write    = wr;
        bus.if_write_ce = wce;
        bus.if_din      = din;
        bus.if_read     = rd;
        bus.if_read_ce  = rce;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, '0, '0);
        tick();
        tick();
        check("rst_full_n", 32'(bus.if_full_n), 32'd1);
        check("rst_empty_n", 32'(bus.if_empty_n), 32'd0);
        check("rst_count", 32'(bus.if_count), 32'd0);
        check("rst_afull", 32'(bus.if_almost_full), 32'd0);
        reset = 1'b0;

        // First write reaches both readers one cycle later.
        drive(1, 1, 8'h01, 2'b00, 2'b00); tick();
        check("first_empty_n", 32'(bus.if_empty_n), 32'd3);
        check("first_dout0", dout_of(0), 32'd1);
        check("first_dout1", dout_of(1), 32'd1);
        drive(0, 0, '0, 2'b11, 2'b11); tick();

        // Skewed readers: ch0 consumes as it goes, ch1 stays idle.
        drive(1, 1, 8'h01, 2'b01, 2'b01); tick();
        for (int v = 2; v <= 4; v++) begin
            drive(1, 1, 8'(v), 2'b01, 2'b01); tick();
        end
        check("full_after4", 32'(bus.if_full_n), 32'd0);
        check("ch1_cnt4", count_of(1), 32'd4);
        drive(1, 1, 8'h05, 2'b01, 2'b01); tick();
        check("blocked_ch1_cnt", count_of(1), 32'd4);
        check("blocked_ch0_cnt", count_of(0), 32'd0);

        // Full release by the slow reader, almost-full follows ch1's count down.
        drive(0, 0, '0, 2'b10, 2'b10); tick();
        check("release_full_n", 32'(bus.if_full_n), 32'd1);
        check("release_afull", 32'(bus.if_almost_full), 32'd1);
        tick();
        check("afull_at2", 32'(bus.if_almost_full), 32'd0);
        tick();
        tick();
        check("ch1_drained", 32'(bus.if_empty_n), 32'd0);

        // Write and read on ch0 in the same cycle.
        drive(1, 1, 8'h11, 2'b00, 2'b00); tick();
        drive(1, 1, 8'h22, 2'b00, 2'b00); tick();
        drive(1, 1, 8'h33, 2'b01, 2'b01); tick();
        check("simul_cnt0", count_of(0), 32'd2);
        check("simul_cnt1", count_of(1), 32'd3);
        check("simul_head0", dout_of(0), 32'h22);

        // Gated or empty reads and gated writes change nothing.
        drive(0, 0, '0, 2'b10, 2'b00); tick();
        check("rce0_cnt1", count_of(1), 32'd3);
        drive(0, 0, '0, 2'b01, 2'b01); tick();
        tick();
        drive(0, 0, '0, 2'b01, 2'b01); tick();
        check("empty_rd_cnt1", count_of(1), 32'd3);
        drive(1, 0, 8'h44, 2'b00, 2'b00); tick();
        check("wce0_cnt1", count_of(1), 32'd3);

        // Drain, rebuild occ=3, then reset against a concurrent write and reads.
        drive(0, 0, '0, 2'b11, 2'b11);
        repeat (4) tick();
        for (int v = 0; v < 3; v++) begin
            drive(1, 1, 8'(8'h50 + v), 2'b00, 2'b00); tick();
        end
        reset = 1'b1;
        drive(1, 1, 8'h77, 2'b11, 2'b11); tick();
        reset = 1'b0;
        check("mid_rst_empty_n", 32'(bus.if_empty_n), 32'd0);
        check("mid_rst_count", 32'(bus.if_count), 32'd0);
        drive(1, 1, 8'hA5, 2'b00, 2'b00); tick();
        drive(1, 1, 8'h5A, 2'b00, 2'b00); tick();
        drive(0, 0, '0, 2'b11, 2'b11); tick();
        tick();

        // Random traffic with occasional gating.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 8'($urandom),
                  2'($urandom), 2'($urandom_range(1, 3)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
